hazard_scoreboard: RTL and testbench
====================================

// Module: hazard_scoreboard
// PURPOSE
//  Parametrised Tuse/Tnew stall-and-forward controller for the 5-stage MIPS core.
//  Replaces per-class opcode matching with a shifting scoreboard of pre-decoded
//  entries: destination register, remaining Tnew and hazard flags for every stage past D.
//  Also owns the mult/div busy counter and the eret/mtc0-EPC interlock.
//  Drives D-stage stall/bubble and the D- and E-stage operand forwarding selects.
// PARAMETERS
//  NSTAGE   3   stages tracked after D (1=E, 2=M, 3=W); minimum 2
//  TW       2   width of the Tnew and Tuse fields
//  MUL_LAT  5   cycles md_busy stays high after a mult/multu leaves E
//  DIV_LAT  10  cycles md_busy stays high after a div/divu leaves E
// PORTS
//  clk          in   1   rising-edge clock
//  reset        in   1   asynchronous, active-low (0 = reset)
//  d_valid      in   1   D holds a real instruction (0 = bubble)
//  d_rs, d_rt   in   5   D source register numbers
//  d_tuse_rs    in   TW  cycles until D needs rs; all-ones = rs not read
//  d_tuse_rt    in   TW  cycles until D needs rt; all-ones = rt not read
//  d_dst        in   5   D destination register; 0 = no write
//  d_tnew       in   TW  cycles after entering E until the result leaves a stage output
//  d_md_use     in   1   D accesses HI/LO (mult/div/mfhi/mflo/mthi/mtlo)
//  d_md_start   in   1   D is mult/multu/div/divu
//  d_md_div     in   1   with d_md_start: 1 = div/divu, 0 = mult/multu
//  d_eret       in   1   D is eret
//  d_mtc0_epc   in   1   D is mtc0 to CP0 register 14
//  flush        in   1   exception/eret flush of all tracked stages
//  stall        out  1   freeze F and D, insert a bubble into E
//  md_busy      out  1   mult/div unit busy
//  fwd_d_rs     out  S   D rs source; S = $clog2(NSTAGE+1); 0 = GRF, k = stage k output
//  fwd_d_rt     out  S   D rt source, same encoding
//  fwd_e_rs     out  S   E rs source, same encoding with k >= 2
//  fwd_e_rt     out  S   E rt source, same encoding with k >= 2
// BEHAVIOUR
//  Entry fields: valid, dst, tnew, rs, rt, tuse flags, md_start, md_div, mtc0_epc.
//  - Each edge, entry k moves to k+1 and tnew saturates down to 0. Entry NSTAGE retires.
//  - Entry 1 loads from D only when d_valid & ~stall & ~flush. Otherwise it becomes a bubble.
//  - flush: on the next edge every entry 1..NSTAGE becomes a bubble. flush wins over stall.
//  Reset: all entries invalid, md counter 0. All outputs 0 in the same cycle (combinational from state).
//  Match: entry valid, dst != 0 and dst == source. The lowest k (youngest) match wins.
//  D forward: fwd = k when the winning entry has tnew == 0. Otherwise 0.
//  Stall:
//  - Any used D source whose winning entry has tnew > tuse.
//  - Or d_md_use & (md_busy | entry1.md_start).
//  - Or d_eret & entry k.mtc0_epc for any k in 1..NSTAGE-1.
//  E forward: same rule applied to entry 1's rs/rt against entries 2..NSTAGE.
//  E needs no stall term; D-stage stalls already cover it.
//  MD counter (sub-block): when entry 1 holds md_start and shifts onward, the counter loads MUL_LAT or DIV_LAT.
//  - It decrements to 0. md_busy = (count != 0).
//  - flush does not cancel a running operation.
//  - Reset mid-operation clears the counter at once.
//  No combinational path from stall back to stall inputs.
//  All stall/forward outputs depend only on D inputs and registered state.
// STRUCTURE
//  hazard_pkg:
//  - TUSE_NONE (all-ones)
//  - stage index constants STG_E=1, STG_M=2, STG_W=3
//  - packed struct sb_entry_t
//  - function fwd_pick(entries, reg) returning the winning stage
//  Sub-module md_busy_ctr: load/decrement counter, ports clk, reset, start, is_div, busy.
//  Scoreboard shift and match logic use generate loops over NSTAGE. No per-opcode decoding inside.
// TESTING
//  1. ALU entry in E (dst=8, tnew=1), D reads r8 with tuse=0 -> stall=1 for 1 cycle, then fwd_d_rs=2 (M).
//  2. Load entry in E (dst=9, tnew=2), D reads r9 with tuse=1 -> stall 1 cycle, then fwd_e_rt=3 (W) next cycle.
//  3. jal in E (dst=31, tnew=0), D jr r31 -> stall=0, fwd_d_rs=1. A write to r0 never matches: fwd=0.
//  4. div leaves E, then mflo in D -> stall held for exactly DIV_LAT cycles, md_busy drops on cycle DIV_LAT.
//  5. mtc0 EPC in E, eret in D -> stall 2 cycles. flush with stall=1 -> all entries cleared and stall drops next cycle.
//  6. reset asserted mid-div with entries valid -> immediately stall=0, md_busy=0, all fwd selects 0.

Source files
------------

// File: rtl/hazard_pkg.sv
// Shared types and helpers for the Tuse/Tnew hazard scoreboard.
// Entries are stored at a fixed maximum depth/width so the helpers stay parameter-free.
package hazard_pkg;
    localparam int SB_MAX = 7;   // deepest stage index a scoreboard may use
    localparam int SB_TW  = 4;   // stored Tnew width, must be >= the top-level TW
    localparam int SB_IW  = 3;   // width of a stage index 0..SB_MAX

    localparam logic [SB_TW-1:0] TUSE_NONE = '1;

    localparam int STG_E = 1;
    localparam int STG_M = 2;
    localparam int STG_W = 3;

    typedef struct packed {
        logic             valid;
        logic [4:0]       dst;
        logic [SB_TW-1:0] tnew;
        logic [4:0]       rs;
        logic [4:0]       rt;
        logic             use_rs;
        logic             use_rt;
        logic             md_start;
        logic             md_div;
        logic             mtc0_epc;
    } sb_entry_t;

    // Index 0 is always a null entry, so a "no match" result can be looked up safely.
    typedef sb_entry_t [SB_MAX:0] sb_tab_t;

    // Youngest (lowest-index) valid entry in lo..hi writing register r; 0 if none.
    function automatic logic [SB_IW-1:0] fwd_pick(input sb_tab_t ents, input logic [4:0] r,
                                                  input int lo, input int hi);
        logic [SB_IW-1:0] win;
        win = '0;
        for (int k = SB_MAX; k >= 1; k--)
            if (k >= lo && k <= hi && ents[k].valid && ents[k].dst != 5'd0 && ents[k].dst == r)
                win = SB_IW'(k);
        return win;
    endfunction

    function automatic sb_entry_t sb_age(input sb_entry_t e);
        sb_entry_t a;
        a      = e;
        a.tnew = (e.tnew == '0) ? '0 : e.tnew - SB_TW'(1);
        return a;
    endfunction
endpackage

// File: rtl/hazard_scoreboard_md.sv
// HI/LO busy counter: loads the unit latency when a mult/div leaves E, counts down to idle.
module md_busy_ctr import hazard_pkg::*; #(
    parameter int MUL_LAT = 5,
    parameter int DIV_LAT = 10
) (
    input  logic clk_i,
    input  logic reset_i,
    input  logic start_i,
    input  logic is_div_i,
    output logic busy_o
);
    localparam int MAXL = (MUL_LAT > DIV_LAT) ? MUL_LAT : DIV_LAT;
    localparam int CW   = $clog2(MAXL + 1);

    logic [CW-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (start_i)
            cnt_d = is_div_i ? CW'(DIV_LAT) : CW'(MUL_LAT);
        else if (cnt_q != '0)
            cnt_d = cnt_q - CW'(1);
    end

    always_ff @(posedge clk_i or negedge reset_i)
        if (!reset_i) cnt_q <= '0;
        else          cnt_q <= cnt_d;

    assign busy_o = (cnt_q != '0);
endmodule

// File: rtl/hazard_scoreboard.sv
// Tuse/Tnew stall-and-forward controller: a shifting scoreboard of pre-decoded entries
// for every stage past D, plus the HI/LO busy and eret/EPC interlocks.
module hazard_scoreboard import hazard_pkg::*; #(
    parameter  int NSTAGE  = 3,
    parameter  int TW      = 2,
    parameter  int MUL_LAT = 5,
    parameter  int DIV_LAT = 10,
    localparam int S       = $clog2(NSTAGE + 1)
) (
    input  logic          clk_i,
    input  logic          reset_i,      // active-low
    input  logic          d_valid_i,
    input  logic [4:0]    d_rs_i,
    input  logic [4:0]    d_rt_i,
    input  logic [TW-1:0] d_tuse_rs_i,
    input  logic [TW-1:0] d_tuse_rt_i,
    input  logic [4:0]    d_dst_i,
    input  logic [TW-1:0] d_tnew_i,
    input  logic          d_md_use_i,
    input  logic          d_md_start_i,
    input  logic          d_md_div_i,
    input  logic          d_eret_i,
    input  logic          d_mtc0_epc_i,
    input  logic          flush_i,
    output logic          stall_o,
    output logic          md_busy_o,
    output logic [S-1:0]  fwd_d_rs_o,
    output logic [S-1:0]  fwd_d_rt_o,
    output logic [S-1:0]  fwd_e_rs_o,
    output logic [S-1:0]  fwd_e_rt_o
);
    sb_entry_t [NSTAGE:1] ent_q;
    sb_entry_t            ent_d [NSTAGE:1];
    sb_tab_t              tab;
    sb_entry_t            e1, d_ent;
    logic                 md_busy, use_rs, use_rt, stall;
    logic                 stall_rs, stall_rt, stall_md, stall_eret;
    logic [SB_IW-1:0]     win_d_rs, win_d_rt, win_e_rs, win_e_rt;
    logic [NSTAGE-1:1]    epc_hit;

    always_comb begin
        tab           = '0;
        tab[NSTAGE:1] = ent_q;
    end

    assign e1     = ent_q[STG_E];
    assign use_rs = d_valid_i && (d_tuse_rs_i != TW'(TUSE_NONE));
    assign use_rt = d_valid_i && (d_tuse_rt_i != TW'(TUSE_NONE));

    // D operands look at every tracked stage, E operands only at stages behind E.
    assign win_d_rs = fwd_pick(tab, d_rs_i, STG_E, NSTAGE);
    assign win_d_rt = fwd_pick(tab, d_rt_i, STG_E, NSTAGE);
    assign win_e_rs = fwd_pick(tab, e1.rs,  STG_M, NSTAGE);
    assign win_e_rt = fwd_pick(tab, e1.rt,  STG_M, NSTAGE);

    assign stall_rs = use_rs && (tab[win_d_rs].tnew > SB_TW'(d_tuse_rs_i));
    assign stall_rt = use_rt && (tab[win_d_rt].tnew > SB_TW'(d_tuse_rt_i));
    assign stall_md = d_valid_i && d_md_use_i && (md_busy || (e1.valid && e1.md_start));

    // An EPC write in the last tracked stage has already reached CP0.
    for (genvar k = 1; k < NSTAGE; k++) begin : g_epc
        assign epc_hit[k] = ent_q[k].valid && ent_q[k].mtc0_epc;
    end
    assign stall_eret = d_valid_i && d_eret_i && (|epc_hit);

    assign stall = stall_rs || stall_rt || stall_md || stall_eret;

    assign fwd_d_rs_o = (use_rs && tab[win_d_rs].tnew == '0) ? S'(win_d_rs) : '0;
    assign fwd_d_rt_o = (use_rt && tab[win_d_rt].tnew == '0) ? S'(win_d_rt) : '0;
    assign fwd_e_rs_o = (e1.valid && e1.use_rs && tab[win_e_rs].tnew == '0) ? S'(win_e_rs) : '0;
    assign fwd_e_rt_o = (e1.valid && e1.use_rt && tab[win_e_rt].tnew == '0) ? S'(win_e_rt) : '0;

    always_comb begin
        d_ent          = '0;
        d_ent.valid    = 1'b1;
        d_ent.dst      = d_dst_i;
        d_ent.tnew     = SB_TW'(d_tnew_i);
        d_ent.rs       = d_rs_i;
        d_ent.rt       = d_rt_i;
        d_ent.use_rs   = use_rs;
        d_ent.use_rt   = use_rt;
        d_ent.md_start = d_md_start_i;
        d_ent.md_div   = d_md_div_i && d_md_start_i;
        d_ent.mtc0_epc = d_mtc0_epc_i;
    end

    assign ent_d[STG_E] = (d_valid_i && !stall && !flush_i) ? d_ent : '0;
    for (genvar k = 2; k <= NSTAGE; k++) begin : g_shift
        assign ent_d[k] = flush_i ? '0 : sb_age(ent_q[k-1]);
    end

    always_ff @(posedge clk_i or negedge reset_i)
        if (!reset_i) ent_q <= '0;
        else for (int k = 1; k <= NSTAGE; k++) ent_q[k] <= ent_d[k];

    md_busy_ctr #(.MUL_LAT(MUL_LAT), .DIV_LAT(DIV_LAT)) u_md (
        .clk_i    (clk_i),
        .reset_i  (reset_i),
        .start_i  (e1.valid && e1.md_start),
        .is_div_i (e1.md_div),
        .busy_o   (md_busy)
    );

    assign stall_o   = stall;
    assign md_busy_o = md_busy;
endmodule

// File: tb/tb_hazard_scoreboard.sv
// Bench for hazard_scoreboard: directed vector table, hand-written multi-cycle sequences,
// then random traffic against an instruction-level reference model.
module tb_hazard_scoreboard;
    import hazard_pkg::*;

    localparam int NSTAGE = 3, TW = 2, MUL_LAT = 5, DIV_LAT = 10, S = 2;
    localparam int TN = 3;  // tuse value meaning "not read"

    logic clk = 1'b0, rst_n = 1'b0;
    logic d_valid, d_md_use, d_md_start, d_md_div, d_eret, d_mtc0_epc, flush;
    logic [4:0] d_rs, d_rt, d_dst;
    logic [TW-1:0] d_tuse_rs, d_tuse_rt, d_tnew;
    logic stall, md_busy;
    logic [S-1:0] fdrs, fdrt, fers, fert;
    int checks = 0, failures = 0;

    always #5 clk = ~clk;

    hazard_scoreboard #(.NSTAGE(NSTAGE), .TW(TW), .MUL_LAT(MUL_LAT), .DIV_LAT(DIV_LAT)) dut (
        .clk_i(clk), .reset_i(rst_n), .d_valid_i(d_valid), .d_rs_i(d_rs), .d_rt_i(d_rt),
        .d_tuse_rs_i(d_tuse_rs), .d_tuse_rt_i(d_tuse_rt), .d_dst_i(d_dst), .d_tnew_i(d_tnew),
        .d_md_use_i(d_md_use), .d_md_start_i(d_md_start), .d_md_div_i(d_md_div),
        .d_eret_i(d_eret), .d_mtc0_epc_i(d_mtc0_epc), .flush_i(flush),
        .stall_o(stall), .md_busy_o(md_busy),
        .fwd_d_rs_o(fdrs), .fwd_d_rt_o(fdrt), .fwd_e_rs_o(fers), .fwd_e_rt_o(fert));

    typedef struct {
        int vld, rs, trs, rt, trt, dst, tn, mdu, mds, mdd, er, epc, fl;
        int s, b, a, c, d, e;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t V(input int vld, rs, trs, rt, trt, dst, tn, mdu, mds, mdd, er, epc, fl,
                               input int s, b, a, c, d, e);
        vec_t v;
        v.vld = vld; v.rs = rs; v.trs = trs; v.rt = rt; v.trt = trt; v.dst = dst; v.tn = tn;
        v.mdu = mdu; v.mds = mds; v.mdd = mdd; v.er = er; v.epc = epc; v.fl = fl;
        v.s = s; v.b = b; v.a = a; v.c = c; v.d = d; v.e = e;
        return v;
    endfunction

    task automatic drive(input int vld, rs, trs, rt, trt, dst, tn, mdu, mds, mdd, er, epc, fl);
        d_valid = 1'(vld); d_rs = 5'(rs); d_tuse_rs = TW'(trs); d_rt = 5'(rt); d_tuse_rt = TW'(trt);
        d_dst = 5'(dst); d_tnew = TW'(tn); d_md_use = 1'(mdu); d_md_start = 1'(mds);
        d_md_div = 1'(mdd); d_eret = 1'(er); d_mtc0_epc = 1'(epc); flush = 1'(fl);
    endtask

    task automatic idle();
        drive(0, 0, TN, 0, TN, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic chk_out(input string tag, input int s, b, a, c, d, e);
        chk({tag, ".stall"},    32'(stall),   s);
        chk({tag, ".md_busy"},  32'(md_busy), b);
        chk({tag, ".fwd_d_rs"}, 32'(fdrs),    a);
        chk({tag, ".fwd_d_rt"}, 32'(fdrt),    c);
        chk({tag, ".fwd_e_rs"}, 32'(fers),    d);
        chk({tag, ".fwd_e_rt"}, 32'(fert),    e);
    endtask

    // Reference model: in-flight instructions tagged with their age since entering E.
    typedef struct { int age, dst, tn, rs, rt, urs, urt, md, dv, epc; } mi_t;
    mi_t q[$];
    int  mcyc, busy_end;

    task automatic m_reset();
        q.delete();
        mcyc = 0;
        busy_end = 0;
    endtask

    task automatic m_find(input int r, input int min_age, output int stg, output int rem);
        stg = 0;
        rem = 0;
        foreach (q[i])
            if (q[i].dst != 0 && q[i].dst == r && q[i].age >= min_age && (stg == 0 || q[i].age + 1 < stg)) begin
                stg = q[i].age + 1;
                rem = (q[i].tn > q[i].age) ? q[i].tn - q[i].age : 0;
            end
    endtask

    task automatic m_eval(output int s, b, a, c, d, e);
        int vld, trs, trt, st, rm, e1;
        vld = int'(d_valid); trs = int'(d_tuse_rs); trt = int'(d_tuse_rt);
        e1 = -1;
        s = 0; a = 0; c = 0; d = 0; e = 0;
        b = (mcyc < busy_end) ? 1 : 0;
        if (vld != 0 && trs != TN) begin
            m_find(int'(d_rs), 0, st, rm);
            if (st != 0 && rm > trs) s = 1;
            if (st != 0 && rm == 0) a = st;
        end
        if (vld != 0 && trt != TN) begin
            m_find(int'(d_rt), 0, st, rm);
            if (st != 0 && rm > trt) s = 1;
            if (st != 0 && rm == 0) c = st;
        end
        foreach (q[i]) if (q[i].age == 0) e1 = i;
        if (vld != 0 && d_md_use && (b != 0 || (e1 >= 0 && q[e1].md != 0))) s = 1;
        if (vld != 0 && d_eret)
            foreach (q[i]) if (q[i].epc != 0 && q[i].age + 1 <= NSTAGE - 1) s = 1;
        if (e1 >= 0) begin
            if (q[e1].urs != 0) begin
                m_find(q[e1].rs, 1, st, rm);
                if (st != 0 && rm == 0) d = st;
            end
            if (q[e1].urt != 0) begin
                m_find(q[e1].rt, 1, st, rm);
                if (st != 0 && rm == 0) e = st;
            end
        end
    endtask

    task automatic m_edge(input int s);
        mi_t n;
        foreach (q[i])
            if (q[i].age == 0 && q[i].md != 0) busy_end = mcyc + 1 + ((q[i].dv != 0) ? DIV_LAT : MUL_LAT);
        if (flush) q.delete();
        else begin
            foreach (q[i]) q[i].age++;
            while (q.size() > 0 && q[q.size()-1].age >= NSTAGE) void'(q.pop_back());
        end
        if (d_valid && s == 0 && !flush) begin
            n.age = 0; n.dst = int'(d_dst); n.tn = int'(d_tnew); n.rs = int'(d_rs); n.rt = int'(d_rt);
            n.urs = (int'(d_tuse_rs) != TN) ? 1 : 0; n.urt = (int'(d_tuse_rt) != TN) ? 1 : 0;
            n.md = int'(d_md_start); n.dv = int'(d_md_div); n.epc = int'(d_mtc0_epc);
            q.push_front(n);
        end
        mcyc++;
    endtask

    initial begin
        int s, b, a, c, d, e;

        //            vld rs trs rt trt dst tn mdu mds mdd er epc fl | stall busy fdrs fdrt fers fert
        tbl.push_back(V(1,  1, 1,  2, 1,   8, 1, 0,0,0,0,0,0,  0,0,0,0,0,0));          // ALU r8
        tbl.push_back(V(1,  8, 0,  0, TN,  0, 0, 0,0,0,0,0,0,  1,0,0,0,0,0));          // r8 not ready
        tbl.push_back(V(1,  8, 0,  0, TN,  0, 0, 0,0,0,0,0,0,  0,0,STG_M,0,0,0));
        tbl.push_back(V(1,  8, 1,  0, TN,  9, 2, 0,0,0,0,0,0,  0,0,STG_W,0,STG_W,0));  // lw r9
        tbl.push_back(V(1,  0, TN, 9, 1,   0, 0, 0,0,0,0,0,0,  1,0,0,0,0,0));
        tbl.push_back(V(1,  0, TN, 9, 1,   0, 0, 0,0,0,0,0,0,  0,0,0,0,0,0));
        tbl.push_back(V(0,  0, TN, 0, TN,  0, 0, 0,0,0,0,0,0,  0,0,0,0,0,STG_W));
        tbl.push_back(V(1,  0, TN, 0, TN, 31, 0, 0,0,0,0,0,0,  0,0,0,0,0,0));          // jal
        tbl.push_back(V(1, 31, 0,  0, TN,  0, 0, 0,0,0,0,0,0,  0,0,STG_E,0,0,0));      // jr r31
        tbl.push_back(V(1, 31, 1,  0, TN,  0, 1, 0,0,0,0,0,0,  0,0,STG_M,0,STG_M,0));  // write r0
        tbl.push_back(V(1,  0, 0,  0, 0,   0, 0, 0,0,0,0,0,0,  0,0,0,0,STG_W,0));      // read r0
        tbl.push_back(V(1,  0, TN, 5, 1,   0, 0, 0,0,0,0,1,0,  0,0,0,0,0,0));          // mtc0 EPC
        tbl.push_back(V(1,  0, TN, 0, TN,  0, 0, 0,0,0,1,0,0,  1,0,0,0,0,0));          // eret
        tbl.push_back(V(1,  0, TN, 0, TN,  0, 0, 0,0,0,1,0,0,  1,0,0,0,0,0));
        tbl.push_back(V(1,  0, TN, 0, TN,  0, 0, 0,0,0,1,0,0,  0,0,0,0,0,0));
        tbl.push_back(V(1,  0, TN, 0, TN, 10, 2, 0,0,0,0,0,0,  0,0,0,0,0,0));          // lw r10
        tbl.push_back(V(1, 10, 0,  0, TN,  0, 0, 0,0,0,0,0,1,  1,0,0,0,0,0));          // stall + flush
        tbl.push_back(V(1, 10, 0,  0, TN,  0, 0, 0,0,0,0,0,0,  0,0,0,0,0,0));

        // Reset state: outputs are 0 even with a hazardous-looking D instruction present.
        drive(1, 8, 0, 8, 0, 8, 3, 1, 1, 1, 1, 1, 0);
        #12;
        chk_out("reset", 0, 0, 0, 0, 0, 0);
        idle();
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        foreach (tbl[i]) begin
            drive(tbl[i].vld, tbl[i].rs, tbl[i].trs, tbl[i].rt, tbl[i].trt, tbl[i].dst, tbl[i].tn,
                  tbl[i].mdu, tbl[i].mds, tbl[i].mdd, tbl[i].er, tbl[i].epc, tbl[i].fl);
            #3;
            chk_out($sformatf("vec%0d", i), tbl[i].s, tbl[i].b, tbl[i].a, tbl[i].c, tbl[i].d, tbl[i].e);
            tick();
        end

        // div then mflo: stall while div in E, then DIV_LAT busy cycles; flush mid-way keeps it busy.
        rst_n = 1'b0; #2; rst_n = 1'b1;
        drive(1, 1, 1, 2, 1, 0, 0, 1, 1, 1, 0, 0, 0);
        #3; chk_out("div", 0, 0, 0, 0, 0, 0);
        tick();
        drive(1, 0, TN, 0, TN, 3, 1, 1, 0, 0, 0, 0, 0);
        #3; chk_out("mflo_e", 1, 0, 0, 0, 0, 0);
        tick();
        for (int i = 1; i <= DIV_LAT; i++) begin
            flush = (i == 4);
            #3; chk_out($sformatf("mflo_busy%0d", i), 1, 1, 0, 0, 0, 0);
            tick();
        end
        flush = 1'b0;
        #3; chk_out("mflo_go", 0, 0, 0, 0, 0, 0);
        tick();

        // Asynchronous reset in the middle of a div with live entries.
        drive(1, 0, TN, 0, TN, 0, 0, 1, 1, 1, 0, 0, 0);
        tick();
        drive(1, 0, TN, 0, TN, 8, 0, 0, 0, 0, 0, 0, 0);
        tick();
        drive(1, 8, 0, 0, TN, 0, 0, 1, 0, 0, 0, 0, 0);
        #2; chk_out("pre_rst", 1, 1, STG_E, 0, 0, 0);
        rst_n = 1'b0;
        #1; chk_out("mid_rst", 0, 0, 0, 0, 0, 0);
        tick();
        rst_n = 1'b1;
        #3; chk_out("post_rst", 0, 0, 0, 0, 0, 0);
        tick();

        // Random traffic against the reference model.
        idle();
        rst_n = 1'b0; #2; rst_n = 1'b1;
        m_reset();
        for (int n = 0; n < 3000; n++) begin
            drive(int'($urandom_range(0, 9) < 8), $urandom_range(0, 3), $urandom_range(0, 3),
                  $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3),
                  int'($urandom_range(0, 7) == 0), int'($urandom_range(0, 15) == 0),
                  $urandom_range(0, 1), int'($urandom_range(0, 7) == 0),
                  int'($urandom_range(0, 7) == 0), int'($urandom_range(0, 31) == 0));
            #3;
            m_eval(s, b, a, c, d, e);
            chk_out($sformatf("rnd%0d", n), s, b, a, c, d, e);
            tick();
            m_edge(s);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
